// File: rtl/rv32i_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Class codes, opcodes, NOP word and immediate width limits.
package rv32i_enc_pkg;

  typedef enum logic [3:0] {
    CLS_LOAD   = 4'd0,
    CLS_STORE  = 4'd1,
    CLS_BRANCH = 4'd2,
    CLS_JALR   = 4'd3,
    CLS_JAL    = 4'd4,
    CLS_ALUI   = 4'd5,
    CLS_AUIPC  = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_RTYPE  = 4'd8,
    CLS_SYSTEM = 4'd9
  } instr_class_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam int unsigned IMM_I_BITS = 12;
  localparam int unsigned IMM_B_BITS = 13;
  localparam int unsigned IMM_J_BITS = 21;

  // True when v fits in a signed field of the given width.
  function automatic logic fits_signed(
    input logic [31:0] v,
    input int unsigned bits
  );
    logic [31:0] hi;
    hi = $signed(v) >>> (bits - 1);
    return (hi == 32'h0) || (hi == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/rv32i_imm_pack.sv
// Places a signed immediate into its format-specific bit positions.
// Flags immediates that cannot be encoded for the given class.
module rv32i_imm_pack
  import rv32i_enc_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [31:0] imm,
  output logic [31:0] imm_bits,
  output logic        imm_err
);

  // Scatter immediate bits and range-check per instruction format.
  always_comb begin
    imm_bits = 32'h0;
    imm_err  = 1'b0;
    case (cls)
      CLS_LOAD, CLS_JALR, CLS_ALUI, CLS_SYSTEM: begin
        imm_bits = {imm[11:0], 20'h0};
        imm_err  = !fits_signed(imm, IMM_I_BITS);
      end
      CLS_STORE: begin
        imm_bits = {imm[11:5], 13'h0, imm[4:0], 7'h0};
        imm_err  = !fits_signed(imm, IMM_I_BITS);
      end
      CLS_BRANCH: begin
        imm_bits = {imm[12], imm[10:5], 13'h0,
                    imm[4:1], imm[11], 7'h0};
        imm_err  = !fits_signed(imm, IMM_B_BITS) | imm[0];
      end
      CLS_JAL: begin
        imm_bits = {imm[20], imm[10:1], imm[11],
                    imm[19:12], 12'h0};
        imm_err  = !fits_signed(imm, IMM_J_BITS) | imm[0];
      end
      CLS_AUIPC, CLS_LUI: begin
        imm_bits = {imm[31:12], 12'h0};
        imm_err  = |imm[11:0];
      end
      default: begin
        imm_bits = 32'h0;
        imm_err  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// Streaming RV32I encoder: 1-cycle latency, output reg plus skid reg.
// Define ENC_STATS_EN to build the saturating beat/error counters.
module rv32i_instr_encoder
  import rv32i_enc_pkg::*;
#(
  parameter logic [31:0] RESET_NOP = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_class,
  input  logic [2:0]  in_funct3,
  input  logic        in_alt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] enc_count,
  output logic [15:0] err_count
);

  logic [31:0] imm_bits;
  logic        imm_err;
  logic [31:0] word;
  logic        fld_err;
  logic        is_shift;
  logic [31:0] enc_word;
  logic        enc_err;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic        skid_err;
  logic        fire_in;
  logic        fire_out;

  rv32i_imm_pack u_imm_pack (
    .cls      (in_class),
    .imm      (in_imm),
    .imm_bits (imm_bits),
    .imm_err  (imm_err)
  );

  assign is_shift = (in_class == CLS_ALUI) &&
                    (in_funct3[1:0] == 2'b01);

  // Merge register/funct fields with the placed immediate.
  always_comb begin
    word    = 32'h0;
    fld_err = 1'b0;
    case (in_class)
      CLS_LOAD:
        word = imm_bits | {12'h0, in_rs1, in_funct3, in_rd, OP_LOAD};
      CLS_JALR:
        word = imm_bits | {12'h0, in_rs1, in_funct3, in_rd, OP_JALR};
      CLS_SYSTEM:
        word = imm_bits | {12'h0, in_rs1, in_funct3, in_rd, OP_SYSTEM};
      CLS_ALUI: begin
        if (is_shift) begin
          word    = {1'b0, in_alt, 5'h0, in_imm[4:0],
                     in_rs1, in_funct3, in_rd, OP_ALUI};
          fld_err = |in_imm[31:5];
        end else begin
          word    = imm_bits |
                    {12'h0, in_rs1, in_funct3, in_rd, OP_ALUI};
          fld_err = imm_err;
        end
      end
      CLS_STORE:
        word = imm_bits |
               {7'h0, in_rs2, in_rs1, in_funct3, 5'h0, OP_STORE};
      CLS_BRANCH:
        word = imm_bits |
               {7'h0, in_rs2, in_rs1, in_funct3, 5'h0, OP_BRANCH};
      CLS_JAL:
        word = imm_bits | {20'h0, in_rd, OP_JAL};
      CLS_AUIPC:
        word = imm_bits | {20'h0, in_rd, OP_AUIPC};
      CLS_LUI:
        word = imm_bits | {20'h0, in_rd, OP_LUI};
      CLS_RTYPE: begin
        word    = {1'b0, in_alt, 5'h0, in_rs2, in_rs1,
                   in_funct3, in_rd, OP_RTYPE};
        fld_err = in_alt &&
                  !((in_funct3 == 3'b000) || (in_funct3 == 3'b101));
      end
      default: begin
        word    = 32'h0;
        fld_err = 1'b1;
      end
    endcase
  end

  assign enc_err  = (in_class == CLS_ALUI) ? fld_err
                                           : (fld_err | imm_err);
  assign enc_word = enc_err ? RESET_NOP : word;

  assign in_ready = ~skid_valid;
  assign fire_in  = in_valid & in_ready;
  assign fire_out = out_valid & out_ready;

  // Output register and skid register; skid drains first to keep order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_instr  <= RESET_NOP;
      out_err    <= 1'b0;
      skid_valid <= 1'b0;
      skid_instr <= RESET_NOP;
      skid_err   <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_instr  <= skid_instr;
        out_err    <= skid_err;
        skid_valid <= 1'b0;
      end else if (fire_in) begin
        out_valid <= 1'b1;
        out_instr <= enc_word;
        out_err   <= enc_err;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (fire_in) begin
      skid_valid <= 1'b1;
      skid_instr <= enc_word;
      skid_err   <= enc_err;
    end
  end

`ifdef ENC_STATS_EN
  // Saturating counters of emitted beats and errored beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_count <= 16'h0;
      err_count <= 16'h0;
    end else if (fire_out) begin
      if (enc_count != 16'hFFFF)
        enc_count <= enc_count + 16'h1;
      if (out_err && (err_count != 16'hFFFF))
        err_count <= err_count + 16'h1;
    end
  end
`else
  logic unused_fire_out;
  assign unused_fire_out = fire_out;
  assign enc_count = 16'h0;
  assign err_count = 16'h0;
`endif

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Directed bench for rv32i_instr_encoder with hand-computed words.
// Counter expectations follow ENC_STATS_EN.
module tb_rv32i_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_class;
  logic [2:0]  in_funct3;
  logic        in_alt;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  int errors = 0;
  int checks = 0;
  int exp_enc = 0;
  int exp_errc = 0;

`ifdef ENC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  rv32i_instr_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .in_funct3 (in_funct3),
    .in_alt    (in_alt),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [3:0] c, input logic [2:0] f3,
                         input logic a, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
    in_class  = c;
    in_funct3 = f3;
    in_alt    = a;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_enc"}, {16'h0, enc_count},
        STATS ? 32'(exp_enc) : 32'h0);
    chk({tag, "_errc"}, {16'h0, err_count},
        STATS ? 32'(exp_errc) : 32'h0);
  endtask

  // One request with out_ready=1; beat checked then consumed.
  task automatic one(input string tag, input logic [3:0] c,
                     input logic [2:0] f3, input logic a,
                     input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] imm,
                     input logic [31:0] exp_w, input logic exp_e);
    set_req(c, f3, a, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({tag, "_v"}, {31'h0, out_valid}, 32'h1);
    chk({tag, "_w"}, out_instr, exp_w);
    chk({tag, "_e"}, {31'h0, out_err}, {31'h0, exp_e});
    @(posedge clk);
    #1;
    exp_enc++;
    if (exp_e) exp_errc++;
  endtask

  logic [31:0] got [3];
  int          beat_cyc [3];
  int          n;
  logic        h_out;
  logic        h_in;
  logic [31:0] v;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_req(4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    #1;
    chk("rst_ready_held", {31'h0, in_ready}, 32'h1);
    #13;
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_instr", out_instr, 32'h0000_0013);
    chk("rst_err", {31'h0, out_err}, 32'h0);
    chk_counts("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", {31'h0, in_ready}, 32'h1);

    one("addi", 4'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0,
        32'd5, 32'h0050_0093, 1'b0);
    one("sub", 4'd8, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2,
        32'h0, 32'h4020_81B3, 1'b0);
    one("sw", 4'd1, 3'b010, 1'b0, 5'd9, 5'd2, 5'd5,
        32'hFFFF_FFFC, 32'hFE51_2E23, 1'b0);
    one("beq_odd", 4'd2, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2,
        32'd3, 32'h0000_0013, 1'b1);
    chk_counts("after_beq");
    one("beq8", 4'd2, 3'b000, 1'b0, 5'd7, 5'd1, 5'd2,
        32'd8, 32'h0020_8463, 1'b0);
    one("lui", 4'd7, 3'b111, 1'b0, 5'd5, 5'd3, 5'd4,
        32'h1234_5000, 32'h1234_52B7, 1'b0);
    one("lui_low", 4'd7, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0,
        32'h1234_5001, 32'h0000_0013, 1'b1);
    one("jal2048", 4'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0,
        32'd2048, 32'h0010_00EF, 1'b0);
    one("jal_m2", 4'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0,
        32'hFFFF_FFFE, 32'hFFFF_F0EF, 1'b0);
    one("jal_big", 4'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0,
        32'h0010_0000, 32'h0000_0013, 1'b1);
    one("addi_max", 4'd5, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0,
        32'd2047, 32'h7FF0_0013, 1'b0);
    one("addi_over", 4'd5, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0,
        32'd2048, 32'h0000_0013, 1'b1);
    one("addi_min", 4'd5, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0,
        32'hFFFF_F800, 32'h8000_0013, 1'b0);
    one("srai", 4'd5, 3'b101, 1'b1, 5'd1, 5'd1, 5'd0,
        32'd3, 32'h4030_D093, 1'b0);
    one("slli32", 4'd5, 3'b001, 1'b0, 5'd1, 5'd1, 5'd0,
        32'd32, 32'h0000_0013, 1'b1);
    one("r_alt_bad", 4'd8, 3'b001, 1'b1, 5'd1, 5'd1, 5'd2,
        32'h0, 32'h0000_0013, 1'b1);
    one("cls12", 4'd12, 3'b000, 1'b0, 5'd1, 5'd1, 5'd2,
        32'h0, 32'h0000_0013, 1'b1);
    chk_counts("vectors");

    // Back-pressure: three requests while out_ready=0.
    out_ready = 1'b0;
    set_req(4'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
    in_valid = 1'b1;
    chk("bp_rdy_a", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    set_req(4'd5, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2);
    chk("bp_rdy_b", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    set_req(4'd5, 3'b000, 1'b0, 5'd3, 5'd0, 5'd0, 32'd3);
    chk("bp_rdy_c", {31'h0, in_ready}, 32'h0);
    @(posedge clk);
    #1;
    chk("bp_hold_rdy", {31'h0, in_ready}, 32'h0);
    chk("bp_hold_w", out_instr, 32'h0010_0093);
    out_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 12 && n < 3; cyc++) begin
      @(negedge clk);
      h_out = out_valid & out_ready;
      h_in  = in_valid & in_ready;
      v     = out_instr;
      @(posedge clk);
      #1;
      if (h_out) begin
        got[n] = v;
        beat_cyc[n] = cyc;
        n++;
        exp_enc++;
      end
      if (h_in) in_valid = 1'b0;
    end
    chk("bp_beats", n, 3);
    if (n == 3) begin
      chk("bp_w0", got[0], 32'h0010_0093);
      chk("bp_w1", got[1], 32'h0020_0113);
      chk("bp_w2", got[2], 32'h0030_0193);
      chk("bp_gap01", {31'h0, (beat_cyc[1] - beat_cyc[0]) <= 2},
          32'h1);
      chk("bp_gap12", {31'h0, (beat_cyc[2] - beat_cyc[1]) <= 2},
          32'h1);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_no_dup", {31'h0, out_valid}, 32'h0);
    chk_counts("bp");

    // Fill output and skid, then pulse reset.
    out_ready = 1'b0;
    set_req(4'd5, 3'b000, 1'b0, 5'd4, 5'd0, 5'd0, 32'd4);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    set_req(4'd5, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'd5);
    @(posedge clk);
    #1;
    chk("full_rdy", {31'h0, in_ready}, 32'h0);
    chk("full_v", {31'h0, out_valid}, 32'h1);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'h0, out_valid}, 32'h0);
    chk("arst_rdy", {31'h0, in_ready}, 32'h1);
    chk("arst_instr", out_instr, 32'h0000_0013);
    exp_enc  = 0;
    exp_errc = 0;
    chk_counts("arst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_clean", {31'h0, out_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_instr_encoder.md
Name: rv32i_instr_encoder

Overview:
- Streaming RV32I instruction encoder: packs field-level requests (class, rd, rs1, rs2, funct3, alt bit, immediate) into 32-bit instruction words. It is the inverse of the core's main decoder.
- Feeds the instruction-memory loader and self-test program generator, and drives the decoder directly in directed core tests.
- Valid/ready on both sides, 1-cycle latency, full throughput, 2-deep buffering (output register plus skid register).

Parameters:
- RESET_NOP, 32'h0000_0013, word driven on out_instr at reset and on any encode error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- in_class  in  4  0 LOAD, 1 STORE, 2 BRANCH, 3 JALR, 4 JAL, 5 ALUI, 6 AUIPC, 7 LUI, 8 RTYPE, 9 SYSTEM; 10-15 illegal.
- in_funct3  in  3  funct3 field.
- in_alt  in  1  funct7[5]: SUB/SRA for RTYPE, SRAI for ALUI shifts.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  byte offset or value, signed; for U-type the full upper value.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts.
- out_instr  out  32  encoded instruction.
- out_err  out  1  request unencodable; out_instr = RESET_NOP.
- enc_count  out  16  instructions emitted (optional feature).
- err_count  out  16  errored words emitted (optional feature).

Behaviour:
- Reset (async, immediate): out_valid=0, skid empty, out_instr=RESET_NOP, out_err=0, counters=0. in_ready=1 while rst is asserted and after release.
- A request held mid-transfer during reset is discarded. The producer must re-present it.
- Input handshake: fires when in_valid && in_ready.
- in_ready = ~skid_valid. It is driven from a register only; there is no combinational path from out_ready.
- Transfers:
  - Output register empty, or draining this cycle (out_ready=1): the accepted word loads the output register. out_valid=1 the next cycle.
  - Output register full and out_ready=0: the accepted word goes to the skid register; in_ready=0 the next cycle.
  - out_ready=1 with skid full: skid moves to the output register, skid is emptied, in_ready=1 the next cycle.
  - A new input cannot arrive in that same cycle, because in_ready was 0.
- Order is preserved. No request is dropped or duplicated.
- out_instr and out_err stay stable while out_valid && !out_ready.
- Opcodes: 0000011, 0100011, 1100011, 1100111, 1101111, 0010011, 0010111, 0110111, 0110011, 1110011 respectively.
- Field placement:
  - I-type (LOAD, JALR, ALUI, SYSTEM): imm[11:0] into bits [31:20].
  - S-type: imm[11:5] into [31:25], imm[4:0] into [11:7].
  - B-type: imm[12|10:5] into [31:25], imm[4:1|11] into [11:7].
  - J-type: imm[20|10:1|11|19:12] into [31:12].
  - U-type: imm[31:12] into [31:12].
  - RTYPE: funct7 = {0, in_alt, 00000}.
  - ALUI funct3 001 or 101: bits [31:25] = {0, in_alt, 00000}; shamt = imm[4:0].
- Unused fields are forced to 0: rs2 for I/U/J, rd for S/B, funct3 for U/J.
- out_err conditions:
  - I-type or S-type: imm not representable as signed 12-bit.
  - B-type: imm not signed 13-bit, or imm[0]=1.
  - J-type: imm not signed 21-bit, or imm[0]=1.
  - U-type: imm[11:0] != 0.
  - ALUI shift: imm[31:5] != 0.
  - in_alt=1 on RTYPE with funct3 other than 000 or 101.
  - in_class >= 10.
- An errored request still occupies one output beat.

Optional Feature:
- ENC_STATS_EN defined:
  - enc_count increments on each output handshake.
  - err_count increments on each output handshake with out_err=1.
  - Both are 16-bit, saturate at 16'hFFFF, and reset to 0.
- ENC_STATS_EN undefined: both ports tied to 0 and no counter flops are built.

Decomposition:
- Package rv32i_enc_pkg:
  - instruction-class enum (4-bit);
  - the ten opcode constants;
  - NOP constant 32'h0000_0013;
  - immediate range-check limits.
- One combinational sub-module, rv32i_imm_pack: class + imm in, placed-immediate bits [31:0] and imm_err out.
- The top level holds the handshake, output register, skid register and counters.

Test Plan:
- ADDI x1,x0,5 (class 5, f3 000, rd 1, imm 5), out_ready=1 -> next cycle out_valid=1, out_instr=0x00500093, out_err=0.
- SUB x3,x1,x2 (class 8, alt 1, rd 3, rs1 1, rs2 2) -> 0x402081B3.
- SW x5,-4(x2) (class 1, f3 010, rs1 2, rs2 5, imm 0xFFFFFFFC) -> 0xFE512E23.
- BEQ with imm=3 -> out_instr=0x00000013, out_err=1; with ENC_STATS_EN, err_count=1 after the beat is consumed.
- out_ready=0 for 3 cycles while 3 back-to-back requests are offered:
  - 2 requests accepted, then in_ready=0;
  - after release, exactly 3 words are emitted in order with no gaps beyond one cycle.
- rst pulsed while the output and skid registers are both full -> out_valid=0, in_ready=1, out_instr=0x00000013 immediately; counters=0.
